// File: rtl/pacman_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pacman_pkg
// Purpose  : Shared direction type, keycodes, LFSR taps and helper functions
//            for the ghost direction generator.
// Revision : 1.0 - initial release
// ============================================================================
package pacman_pkg;

  typedef enum logic [1:0] {
    LEFT  = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    UP    = 2'd3
  } dir_t;

  localparam logic [7:0]  KEY_LEFT  = 8'h1A;
  localparam logic [7:0]  KEY_RIGHT = 8'h04;
  localparam logic [7:0]  KEY_DOWN  = 8'h07;
  localparam logic [7:0]  KEY_UP    = 8'h16;
  localparam logic [7:0]  KEY_NONE  = 8'h00;

  // Galois mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [7:0] dir_to_key(input dir_t d);
    logic [7:0] k;
    case (d)
      LEFT:    k = KEY_LEFT;
      RIGHT:   k = KEY_RIGHT;
      DOWN:    k = KEY_DOWN;
      UP:      k = KEY_UP;
      default: k = KEY_NONE;
    endcase
    return k;
  endfunction

  // Opposite direction: LEFT<->RIGHT, DOWN<->UP
  function automatic dir_t reverse(input dir_t d);
    return dir_t'(d ^ 2'b01);
  endfunction

endpackage : pacman_pkg
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : lfsr16
// Purpose  : 16-bit right-shifting Galois LFSR. Advances once per step
//            strobe unless held; loads the seed on reset.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr16
  import pacman_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        hold,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  // Next value: shift right, fold taps back in when the shifted-out bit is 1
  always_comb begin
    q_d = q_q;
    if (!hold && step) begin
      q_d = {1'b0, q_q[15:1]} ^ (q_q[0] ? LFSR_TAPS : 16'h0000);
    end
  end

  // State register, seeded on reset
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      q_q <= seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : lfsr16
`default_nettype wire

// File: rtl/ghost_dir_gen.sv
`default_nettype none
// ============================================================================
// Module   : ghost_dir_gen
// Purpose  : Per-ghost direction generator. On each frame tick, keeps or
//            changes direction based on wall flags, a dwell timer and an
//            LFSR, and emits the corresponding movement keycode.
// Revision : 1.0 - initial release
// ============================================================================
module ghost_dir_gen
  import pacman_pkg::*;
#(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned DWELL_SEC = 3
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       pause,
  input  logic       sec,
  input  logic [4:0] mapL,
  input  logic [4:0] mapR,
  input  logic [4:0] mapB,
  input  logic [4:0] mapT,
  output logic [7:0] randomkeycode,
  output logic       dir_change
);

  localparam logic [3:0] DWELL_MAX = 4'(DWELL_SEC);

  logic        f1_q, f2_q, f3_q;
  logic        tick;

  dir_t        dir_q, dir_d;
  logic        first_q, first_d;
  logic [3:0]  dwell_q, dwell_d;
  logic [7:0]  key_q, key_d;
  logic        dir_change_q, dir_change_d;

  logic [15:0] lfsr_q;
  logic [3:0]  open_w;
  logic        expired;
  logic        redirect;
  dir_t        chosen;
  logic        found;
  dir_t        cand;

  // Frame strobe synchronizer and rising-edge detector
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      f1_q <= 1'b0;
      f2_q <= 1'b0;
      f3_q <= 1'b0;
    end else begin
      f1_q <= frame_clk;
      f2_q <= f1_q;
      f3_q <= f2_q;
    end
  end

  assign tick = f2_q & ~f3_q;

  // Random source; decisions below use the value before this tick's advance
  lfsr16 u_lfsr (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .hold    (pause),
    .step    (tick & ~pause),
    .seed    (SEED),
    .q       (lfsr_q)
  );

  // Direction selection: first open non-reverse candidate, then reverse, else keep
  always_comb begin
    open_w[LEFT]  = (mapL == 5'd0);
    open_w[RIGHT] = (mapR == 5'd0);
    open_w[DOWN]  = (mapB == 5'd0);
    open_w[UP]    = (mapT == 5'd0);

    expired  = (dwell_q == DWELL_MAX);
    redirect = first_q | ~open_w[dir_q] | expired;

    chosen = dir_q;
    found  = 1'b0;
    cand   = LEFT;
    for (int i = 0; i < 4; i++) begin
      cand = dir_t'(lfsr_q[1:0] + 2'(i));
      if (!found && open_w[cand] && (first_q || (cand != reverse(dir_q)))) begin
        chosen = cand;
        found  = 1'b1;
      end
    end
    if (!found && open_w[reverse(dir_q)]) begin
      chosen = reverse(dir_q);
    end
  end

  // Next-state: pause forces idle; otherwise dwell counting and tick decisions
  always_comb begin
    dir_d        = dir_q;
    first_d      = first_q;
    dwell_d      = dwell_q;
    key_d        = key_q;
    dir_change_d = 1'b0;

    if (pause) begin
      dir_d   = LEFT;
      first_d = 1'b1;
      dwell_d = 4'd0;
      key_d   = KEY_NONE;
    end else begin
      if (sec && !expired) begin
        dwell_d = dwell_q + 4'd1;
      end
      if (tick) begin
        if (redirect) begin
          dir_d        = chosen;
          key_d        = dir_to_key(chosen);
          first_d      = 1'b0;
          dwell_d      = 4'd0;
          dir_change_d = (dir_to_key(chosen) != key_q);
        end else begin
          key_d = dir_to_key(dir_q);
        end
      end
    end
  end

  // Decision state registers
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      dir_q        <= LEFT;
      first_q      <= 1'b1;
      dwell_q      <= 4'd0;
      key_q        <= KEY_NONE;
      dir_change_q <= 1'b0;
    end else begin
      dir_q        <= dir_d;
      first_q      <= first_d;
      dwell_q      <= dwell_d;
      key_q        <= key_d;
      dir_change_q <= dir_change_d;
    end
  end

  assign randomkeycode = key_q;
  assign dir_change    = dir_change_q;

endmodule : ghost_dir_gen
`default_nettype wire

// File: tb/tb_ghost_dir_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_ghost_dir_gen
// Purpose  : Directed, table-driven self-checking bench for ghost_dir_gen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ghost_dir_gen;

  logic       clk;
  logic       rst_n;
  logic       frame_clk;
  logic       pause;
  logic       sec;
  logic [4:0] mapL, mapR, mapB, mapT;
  logic [7:0] randomkeycode;
  logic       dir_change;

  int n_vec;
  int n_fail;

  typedef struct {
    logic [4:0]  l, r, b, t;
    logic [7:0]  key;
    logic        dc;
    logic [15:0] lfsr;
  } vec_t;

  vec_t vecs [8];

  ghost_dir_gen #(
    .SEED      (16'hACE1),
    .DWELL_SEC (3)
  ) dut (
    .Clk           (clk),
    .Reset_n       (rst_n),
    .frame_clk     (frame_clk),
    .pause         (pause),
    .sec           (sec),
    .mapL          (mapL),
    .mapR          (mapR),
    .mapB          (mapB),
    .mapT          (mapT),
    .randomkeycode (randomkeycode),
    .dir_change    (dir_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic set_maps(input logic [4:0] l, r, b, t);
    mapL = l; mapR = r; mapB = b; mapT = t;
  endtask

  task automatic sec_pulse();
    sec = 1'b1;
    @(negedge clk);
    sec = 1'b0;
  endtask

  // One frame pulse; checks latency and the result at edge k+2
  task automatic tick_chk(input string name, input logic sec_on_tick,
                          input logic [7:0] key, input logic dc, input logic [15:0] lf);
    frame_clk = 1'b1;
    @(negedge clk);          // edge k
    frame_clk = 1'b0;
    @(negedge clk);          // edge k+1, tick pending
    chk({name, ".dc_early"}, {31'd0, dir_change}, 32'd0);
    sec = sec_on_tick;
    @(negedge clk);          // edge k+2
    sec = 1'b0;
    chk({name, ".key"}, {24'd0, randomkeycode}, {24'd0, key});
    chk({name, ".dc"},  {31'd0, dir_change},    {31'd0, dc});
    chk({name, ".lfsr"}, {16'd0, dut.lfsr_q},   {16'd0, lf});
    @(negedge clk);
  endtask

  initial begin
    n_vec = 0; n_fail = 0;
    rst_n = 1'b0; frame_clk = 1'b0; pause = 1'b0; sec = 1'b0;
    set_maps(5'd0, 5'd0, 5'd0, 5'd0);

    //          L      R      B      T      key    dc    lfsr after
    vecs[0] = '{5'h00, 5'h00, 5'h00, 5'h00, 8'h04, 1'b1, 16'hE270};
    vecs[1] = '{5'h00, 5'h00, 5'h00, 5'h00, 8'h04, 1'b0, 16'h7138};
    vecs[2] = '{5'h00, 5'h01, 5'h1F, 5'h1F, 8'h1A, 1'b1, 16'h389C};
    vecs[3] = '{5'h01, 5'h01, 5'h1F, 5'h1F, 8'h1A, 1'b0, 16'h1C4E};
    vecs[4] = '{5'h00, 5'h00, 5'h00, 5'h00, 8'h1A, 1'b0, 16'h0E27};
    vecs[5] = '{5'h01, 5'h00, 5'h00, 5'h00, 8'h16, 1'b1, 16'hB313};
    vecs[6] = '{5'h00, 5'h00, 5'h00, 5'h02, 8'h1A, 1'b1, 16'hED89};
    vecs[7] = '{5'h01, 5'h01, 5'h00, 5'h01, 8'h07, 1'b1, 16'hC2C4};

    // Reset and idle
    repeat (2) @(negedge clk);
    chk("rst.key",  {24'd0, randomkeycode}, 32'h00);
    chk("rst.dc",   {31'd0, dir_change},    32'd0);
    chk("rst.lfsr", {16'd0, dut.lfsr_q},    32'hACE1);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle.key",  {24'd0, randomkeycode}, 32'h00);
    chk("idle.lfsr", {16'd0, dut.lfsr_q},    32'hACE1);

    // Table: first tick, reversal as last resort, blocked, choice order
    for (int i = 0; i < 8; i++) begin
      set_maps(vecs[i].l, vecs[i].r, vecs[i].b, vecs[i].t);
      tick_chk($sformatf("vec%0d", i), 1'b0, vecs[i].key, vecs[i].dc, vecs[i].lfsr);
    end

    // Dwell: two seconds, no redirect
    set_maps(5'd0, 5'd0, 5'd0, 5'd0);
    sec_pulse(); sec_pulse();
    tick_chk("dwell2", 1'b0, 8'h07, 1'b0, 16'h6162);
    chk("dwell2.cnt", {28'd0, dut.dwell_q}, 32'd2);
    // Third second: expiry redirects (same direction wins), dwell cleared
    sec_pulse();
    tick_chk("dwell3", 1'b0, 8'h07, 1'b0, 16'h30B1);
    chk("dwell3.cnt", {28'd0, dut.dwell_q}, 32'd0);
    // Expired with a coincident sec: the sec is consumed
    sec_pulse(); sec_pulse(); sec_pulse();
    tick_chk("dwellco", 1'b1, 8'h04, 1'b1, 16'hAC58);
    chk("dwellco.cnt", {28'd0, dut.dwell_q}, 32'd0);
    // Dwell 2 with coincident sec: expiry judged on pre-increment value
    sec_pulse(); sec_pulse();
    tick_chk("dwellpre", 1'b1, 8'h04, 1'b0, 16'h562C);
    chk("dwellpre.cnt", {28'd0, dut.dwell_q}, 32'd3);
    tick_chk("dwellexp", 1'b0, 8'h04, 1'b0, 16'h2B16);
    chk("dwellexp.cnt", {28'd0, dut.dwell_q}, 32'd0);

    // Pause: keycode clears at once, LFSR frozen across ticks
    pause = 1'b1;
    @(negedge clk);
    chk("pause.key", {24'd0, randomkeycode}, 32'h00);
    chk("pause.dc",  {31'd0, dir_change},    32'd0);
    for (int i = 0; i < 10; i++) begin
      frame_clk = 1'b1;
      @(negedge clk);
      frame_clk = 1'b0;
      repeat (3) @(negedge clk);
    end
    chk("pause.lfsr",  {16'd0, dut.lfsr_q},    32'h2B16);
    chk("pause.key2",  {24'd0, randomkeycode}, 32'h00);
    pause = 1'b0;
    @(negedge clk);
    // Only RIGHT open: reverse of LEFT allowed right after pause
    set_maps(5'h01, 5'h00, 5'h01, 5'h01);
    tick_chk("unpause", 1'b0, 8'h04, 1'b1, 16'h158B);

    // Reset with a tick pending
    set_maps(5'd0, 5'd0, 5'd0, 5'd0);
    frame_clk = 1'b1;
    @(negedge clk);
    frame_clk = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.key",  {24'd0, randomkeycode}, 32'h00);
    chk("midrst.dc",   {31'd0, dir_change},    32'd0);
    chk("midrst.lfsr", {16'd0, dut.lfsr_q},    32'hACE1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst.idle", {24'd0, randomkeycode}, 32'h00);
    tick_chk("postrst", 1'b0, 8'h04, 1'b1, 16'hE270);

    // Held-high frame strobe yields a single tick
    frame_clk = 1'b1;
    repeat (6) @(negedge clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge clk);
    chk("held.lfsr", {16'd0, dut.lfsr_q},    32'h7138);
    chk("held.key",  {24'd0, randomkeycode}, 32'h04);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_ghost_dir_gen
`default_nettype wire

// File: doc/ghost_dir_gen.md
# ghost_dir_gen

Per-ghost direction generator that produces the 8-bit direction keycode consumed by a ghost movement block, standing in for the player keyboard. On each frame tick it decides whether to keep or change direction from the four wall-lookup flags, a dwell timer driven by the 1 Hz `sec` pulse, and a 16-bit LFSR. One instance sits directly upstream of each ghost movement module; its `randomkeycode` output feeds that module's `randomkeycode` input.

## Interface
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `DWELL_SEC`, 3: `sec` pulses after which a redirect is forced; range 1..15.
- `Clk` in 1: system clock.
- `Reset_n` in 1: reset, synchronous, active-low.
- `frame_clk` in 1: frame strobe level; synchronized and rising-edge detected internally.
- `pause` in 1: game paused / ghost recentring.
- `sec` in 1: one-`Clk`-cycle pulse, once per second.
- `mapL`, `mapR`, `mapB`, `mapT` in 5 each: wall lookup beside the ghost; zero = open, nonzero = wall.
- `randomkeycode` out 8: direction code. 8'h1A = left, 8'h04 = right, 8'h07 = down, 8'h16 = up, 8'h00 = none.
- `dir_change` out 1: one-cycle pulse on the cycle `randomkeycode` takes a new direction.

## Operation
- Direction enum `dir_t`: LEFT=0, RIGHT=1, DOWN=2, UP=3. Reverse of d = d ^ 2'b01.
- Registers:
  - `dir`
  - `first`: no valid current direction yet.
  - `dwell`, 4 bits.
  - `lfsr`, 16 bits.
  - `randomkeycode`.
  - frame sync flops f1, f2, f3.
- Frame tick: tick = f2 & ~f3.
- LFSR: Galois, polynomial x^16+x^14+x^13+x^11+1 (mask 16'hB400). Advances exactly once per tick, never otherwise. Decisions use the pre-advance value.
- Dwell:
  - Increments on `sec`, saturating at DWELL_SEC.
  - Expired when `dwell` == DWELL_SEC.
- Redirect condition at a tick, when not paused: `first`, OR current `dir` blocked (its map flag nonzero), OR dwell expired.
- Choice on redirect:
  - Candidates c_i = (lfsr[1:0] + i) mod 4, for i = 0..3.
  - Pick the first c_i that is open and is not the reverse of `dir`. The reverse exclusion is ignored when `first` = 1.
  - If none qualifies, pick the reverse of `dir` if it is open.
  - If nothing is open, keep `dir`.
- On redirect:
  - `dir` and `randomkeycode` take the chosen value; `first` clears; `dwell` clears to 0 (a coincident `sec` is consumed).
  - `dir_change` is 1 only if the chosen value differs from the previous `randomkeycode`.
- No redirect at a tick: `randomkeycode` re-drives `dir`'s code; the LFSR still advances.
- Pause, at every cycle while high (overrides tick and `sec`):
  - `randomkeycode` = 8'h00, `dwell` = 0, `first` = 1, `dir` = LEFT, `dir_change` = 0.
  - LFSR holds.
- Reset (`Reset_n` low at a `Clk` edge): same values as pause, plus `lfsr` = SEED and f1/f2/f3 = 0. Reset mid-operation discards any pending tick.

## Timing
- `frame_clk` rising before Clk edge k: f1 high after k, tick high after k+1, `randomkeycode`/`dir_change` update at edge k+2. Latency is 3 edges.
- Map flags, `pause`, and `sec` are sampled on the tick cycle (edge k+2).
- `frame_clk` held high produces exactly one tick.
- `sec` and tick in the same cycle: expiry is evaluated on the pre-increment `dwell`.
- `pause` deasserted: the first subsequent tick always redirects (`first` = 1).
- Outputs are fully registered; there is no combinational input-to-output path.

## Structure
- `pacman_pkg` holds:
  - `dir_t`.
  - Constants KEY_LEFT, KEY_RIGHT, KEY_DOWN, KEY_UP, KEY_NONE.
  - Functions `dir_to_key(dir_t)` and `reverse(dir_t)`.
  - The mask LFSR_TAPS = 16'hB400.
- Sub-module `lfsr16`, with ports `Clk`, `Reset_n`, `hold`, `step`, `seed`, `q`. `ghost_dir_gen` instantiates it with `step` = tick & ~pause.

## Test plan
- Reset then idle: after `Reset_n` low for 2 cycles, `randomkeycode` = 8'h00, `dir_change` = 0, LFSR = 16'hACE1. No tick means no change.
- First tick, all map flags 0: `randomkeycode` = `dir_to_key(16'hACE1[1:0])`, i.e. lfsr[1:0] = 01 gives 8'h04. `dir_change` pulses on edge k+2 exactly.
- Reversal only as last resort:
  - Set: `dir` = RIGHT, mapR = 1, mapL = 0, mapT = mapB = 5'h1F.
  - Next tick: `randomkeycode` = 8'h1A.
  - Then all flags nonzero: keycode holds 8'h1A, `dir_change` = 0.
- Dwell, DWELL_SEC = 3, all flags open:
  - Two `sec` pulses then a tick: no redirect.
  - Third pulse then a tick: redirect evaluated, `dwell` returns to 0.
  - A `sec` coincident with that tick does not leave `dwell` = 1.
- Pause mid-run: `pause` high gives keycode 8'h00 on the next edge, and the LFSR is unchanged across 10 ticks. After release, the next tick yields a nonzero keycode with reverse exclusion ignored.
- Reset mid-operation: assert `Reset_n` low on the cycle a tick is pending. Required: no `dir_change`, keycode 8'h00, LFSR = SEED. The first tick after release reproduces the same decision as the post-reset first-tick scenario.
